// File: rtl/wishbone_rr_arbiter_pkg.sv
// Shared types for the two-master Wishbone round-robin arbiter: FSM states,
// bus field widths and the tie-break helper used in IDLE.
package wishbone_rr_arbiter_pkg;

  localparam int CTI_W = 3;
  localparam int BTE_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  // last_gnt names the master served most recently (0 or 1); on a tie the other one wins.
  function automatic arb_state_t arb_pick(input logic cyc0, input logic cyc1,
                                          input logic last_gnt);
    arb_state_t pick;
    pick = IDLE;
    if (cyc0 && (!cyc1 || last_gnt)) pick = GNT0;
    else if (cyc1) pick = GNT1;
    return pick;
  endfunction

endpackage

// File: rtl/wishbone_rr_arbiter_timeout.sv
// Bus-timeout watchdog for the granted master; only built with WB_ARB_TIMEOUT_EN.
// Pulses timeout for one cycle after TIMEOUT_CYCLES strobed cycles without a response.
`ifdef WB_ARB_TIMEOUT_EN
module wb_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic stb,
  input  logic done,
  output logic timeout
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      count   <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (done) begin
        count <= '0;
      end else if (stb) begin
        if (count == CW'(TIMEOUT_CYCLES - 1)) begin
          count   <= '0;
          timeout <= 1'b1;
        end else begin
          count <= count + CW'(1);
        end
      end
    end
  end

endmodule
`endif

// File: rtl/wishbone_rr_arbiter.sv
// Two-master to one-slave Wishbone round-robin arbiter, 1-cycle arbitration, grant held while cyc is high;
// pure mux data path, losing master stalls on ack=0. Optional bus timeout under WB_ARB_TIMEOUT_EN.
module wishbone_rr_arbiter
  import wishbone_rr_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 30,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int SEL_W         = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] m0_adr,
  input  logic [DATA_W-1:0] m0_dat_w,
  input  logic [SEL_W-1:0]  m0_sel,
  input  logic              m0_cyc,
  input  logic              m0_stb,
  input  logic              m0_we,
  input  logic [CTI_W-1:0]  m0_cti,
  input  logic [BTE_W-1:0]  m0_bte,
  output logic [DATA_W-1:0] m0_dat_r,
  output logic              m0_ack,
  output logic              m0_err,
  input  logic [ADDR_W-1:0] m1_adr,
  input  logic [DATA_W-1:0] m1_dat_w,
  input  logic [SEL_W-1:0]  m1_sel,
  input  logic              m1_cyc,
  input  logic              m1_stb,
  input  logic              m1_we,
  input  logic [CTI_W-1:0]  m1_cti,
  input  logic [BTE_W-1:0]  m1_bte,
  output logic [DATA_W-1:0] m1_dat_r,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [ADDR_W-1:0] s_adr,
  output logic [DATA_W-1:0] s_dat_w,
  output logic [SEL_W-1:0]  s_sel,
  output logic              s_cyc,
  output logic              s_stb,
  output logic              s_we,
  output logic [CTI_W-1:0]  s_cti,
  output logic [BTE_W-1:0]  s_bte,
  input  logic [DATA_W-1:0] s_dat_r,
  input  logic              s_ack,
  input  logic              s_err
);

  typedef struct packed {
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] dat_w;
    logic [SEL_W-1:0]  sel;
    logic              we;
    logic [CTI_W-1:0]  cti;
    logic [BTE_W-1:0]  bte;
    logic              cyc;
    logic              stb;
  } wb_req_t;

  arb_state_t state, state_nxt;
  logic       last_gnt, last_gnt_nxt;
  logic       tmo;
  wb_req_t    req0, req1, req_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
    end else begin
      state    <= state_nxt;
      last_gnt <= last_gnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    last_gnt_nxt = last_gnt;
    case (state)
      IDLE: state_nxt = arb_pick(m0_cyc, m1_cyc, last_gnt);
      GNT0: if (!m0_cyc) begin
        state_nxt    = IDLE;
        last_gnt_nxt = 1'b0;
      end
      GNT1: if (!m1_cyc) begin
        state_nxt    = IDLE;
        last_gnt_nxt = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign req0 = '{adr: m0_adr, dat_w: m0_dat_w, sel: m0_sel, we: m0_we,
                  cti: m0_cti, bte: m0_bte, cyc: m0_cyc, stb: m0_stb};
  assign req1 = '{adr: m1_adr, dat_w: m1_dat_w, sel: m1_sel, we: m1_we,
                  cti: m1_cti, bte: m1_bte, cyc: m1_cyc, stb: m1_stb};

  // Gating with rst_n keeps the bus quiet and drops any in-flight ack while reset is held.
  assign req_s = !rst_n          ? '0   :
                 (state == GNT0) ? req0 :
                 (state == GNT1) ? req1 : '0;

  assign s_adr   = req_s.adr;
  assign s_dat_w = req_s.dat_w;
  assign s_sel   = req_s.sel;
  assign s_we    = req_s.we;
  assign s_cti   = req_s.cti;
  assign s_bte   = req_s.bte;
  assign s_cyc   = req_s.cyc;
  assign s_stb   = req_s.stb;

`ifdef WB_ARB_TIMEOUT_EN
  wb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state == IDLE),
    .stb    (req_s.stb),
    .done   (s_ack | s_err),
    .timeout(tmo)
  );
`else
  localparam int tmo_unused = TIMEOUT_CYCLES;
  assign tmo = 1'b0;
`endif

  assign m0_dat_r = s_dat_r;
  assign m1_dat_r = s_dat_r;
  assign m0_ack   = rst_n && (state == GNT0) && s_ack;
  assign m1_ack   = rst_n && (state == GNT1) && s_ack;
  assign m0_err   = rst_n && (state == GNT0) && (s_err || tmo);
  assign m1_err   = rst_n && (state == GNT1) && (s_err || tmo);

endmodule

// File: tb/tb_wishbone_rr_arbiter.sv
// Directed bench for wishbone_rr_arbiter: per-cycle vector table plus burst-lock and timeout sequences.
module tb_wishbone_rr_arbiter;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int SEL_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] m0_adr, m1_adr, s_adr;
  logic [DATA_W-1:0] m0_dat_w, m1_dat_w, s_dat_w, m0_dat_r, m1_dat_r, s_dat_r;
  logic [SEL_W-1:0]  m0_sel, m1_sel, s_sel;
  logic              m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [2:0]        m0_cti, m1_cti, s_cti;
  logic [1:0]        m0_bte, m1_bte, s_bte;
  logic              m0_ack, m0_err, m1_ack, m1_err;
  logic              s_cyc, s_stb, s_we, s_ack, s_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wishbone_rr_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_adr(m0_adr), .m0_dat_w(m0_dat_w), .m0_sel(m0_sel), .m0_cyc(m0_cyc),
    .m0_stb(m0_stb), .m0_we(m0_we), .m0_cti(m0_cti), .m0_bte(m0_bte),
    .m0_dat_r(m0_dat_r), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_adr(m1_adr), .m1_dat_w(m1_dat_w), .m1_sel(m1_sel), .m1_cyc(m1_cyc),
    .m1_stb(m1_stb), .m1_we(m1_we), .m1_cti(m1_cti), .m1_bte(m1_bte),
    .m1_dat_r(m1_dat_r), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_adr(s_adr), .s_dat_w(s_dat_w), .s_sel(s_sel), .s_cyc(s_cyc),
    .s_stb(s_stb), .s_we(s_we), .s_cti(s_cti), .s_bte(s_bte),
    .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err)
  );

  // own: 0 = bus idle (all request fields 0), 1 = master 0 muxed, 2 = master 1 muxed
  typedef struct {
    logic       rst;
    logic       c0;
    logic       c1;
    logic       ack;
    logic       err;
    logic       e_cyc;
    logic [1:0] own;
    logic       a0;
    logic       a1;
    logic       r0;
    logic       r1;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic rst, c0, c1, ack, err, e_cyc,
                              input logic [1:0] own, input logic a0, a1, r0, r1);
    vec_t v;
    v = '{rst, c0, c1, ack, err, e_cyc, own, a0, a1, r0, r1};
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic rst, c0, c1, ack, err);
    rst_n  = rst;
    m0_cyc = c0;
    m0_stb = c0;
    m1_cyc = c1;
    m1_stb = c1;
    s_ack  = ack;
    s_err  = err;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int errs;
    m0_adr = 30'h100; m0_dat_w = 32'hA0A0_0000; m0_sel = 4'hF; m0_we = 1'b0;
    m0_cti = 3'b000;  m0_bte = 2'b00;
    m1_adr = 30'h200; m1_dat_w = 32'hB1B1_0000; m1_sel = 4'h3; m1_we = 1'b1;
    m1_cti = 3'b000;  m1_bte = 2'b00;
    s_dat_r = '0;
    apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    //            rst c0 c1 ack err | cyc own  a0 a1 r0 r1
    vecs[0]  = mk(0, 1, 1, 0, 0,  0, 2'd0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 1, 1, 0, 0,  0, 2'd0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 1, 1, 1, 0,  0, 2'd0, 0, 0, 0, 0);
    vecs[3]  = mk(1, 1, 1, 0, 0,  0, 2'd0, 0, 0, 0, 0);
    vecs[4]  = mk(1, 1, 1, 0, 0,  1, 2'd1, 0, 0, 0, 0);
    vecs[5]  = mk(1, 1, 1, 1, 0,  1, 2'd1, 1, 0, 0, 0);
    vecs[6]  = mk(1, 0, 1, 0, 0,  0, 2'd1, 0, 0, 0, 0);
    vecs[7]  = mk(1, 1, 1, 0, 0,  0, 2'd0, 0, 0, 0, 0);
    vecs[8]  = mk(1, 1, 1, 0, 0,  1, 2'd2, 0, 0, 0, 0);
    vecs[9]  = mk(1, 1, 1, 1, 0,  1, 2'd2, 0, 1, 0, 0);
    vecs[10] = mk(1, 1, 0, 0, 0,  0, 2'd2, 0, 0, 0, 0);
    vecs[11] = mk(1, 1, 1, 0, 0,  0, 2'd0, 0, 0, 0, 0);
    vecs[12] = mk(1, 1, 1, 1, 0,  1, 2'd1, 1, 0, 0, 0);
    vecs[13] = mk(1, 0, 1, 0, 0,  0, 2'd1, 0, 0, 0, 0);
    vecs[14] = mk(1, 0, 1, 0, 0,  0, 2'd0, 0, 0, 0, 0);
    vecs[15] = mk(1, 0, 1, 0, 1,  1, 2'd2, 0, 0, 0, 1);
    vecs[16] = mk(1, 1, 1, 0, 0,  1, 2'd2, 0, 0, 0, 0);
    vecs[17] = mk(1, 1, 1, 1, 0,  1, 2'd2, 0, 1, 0, 0);
    vecs[18] = mk(1, 1, 0, 0, 0,  0, 2'd2, 0, 0, 0, 0);
    vecs[19] = mk(1, 1, 0, 0, 0,  0, 2'd0, 0, 0, 0, 0);
    vecs[20] = mk(0, 1, 0, 1, 0,  0, 2'd0, 0, 0, 0, 0);
    vecs[21] = mk(1, 1, 0, 0, 0,  0, 2'd0, 0, 0, 0, 0);
    vecs[22] = mk(1, 1, 0, 0, 0,  1, 2'd1, 0, 0, 0, 0);
    vecs[23] = mk(1, 0, 0, 0, 0,  0, 2'd1, 0, 0, 0, 0);
    vecs[24] = mk(1, 0, 0, 0, 0,  0, 2'd0, 0, 0, 0, 0);

    for (int i = 0; i < NV; i++) begin
      logic [ADDR_W-1:0] e_adr;
      logic [DATA_W-1:0] e_dat;
      logic [SEL_W-1:0]  e_sel;
      logic              e_we;
      apply(vecs[i].rst, vecs[i].c0, vecs[i].c1, vecs[i].ack, vecs[i].err);
      s_dat_r = 32'hD000_0000 + DATA_W'(i);
      case (vecs[i].own)
        2'd1:    begin e_adr = 30'h100; e_dat = 32'hA0A0_0000; e_sel = 4'hF; e_we = 1'b0; end
        2'd2:    begin e_adr = 30'h200; e_dat = 32'hB1B1_0000; e_sel = 4'h3; e_we = 1'b1; end
        default: begin e_adr = '0;      e_dat = '0;            e_sel = '0;   e_we = 1'b0; end
      endcase
      @(negedge clk);
      chk($sformatf("row%0d s_cyc", i),   s_cyc,   vecs[i].e_cyc);
      chk($sformatf("row%0d s_stb", i),   s_stb,   vecs[i].e_cyc);
      chk($sformatf("row%0d s_adr", i),   s_adr,   e_adr);
      chk($sformatf("row%0d s_dat_w", i), s_dat_w, e_dat);
      chk($sformatf("row%0d s_sel", i),   s_sel,   e_sel);
      chk($sformatf("row%0d s_we", i),    s_we,    e_we);
      chk($sformatf("row%0d m0_ack", i),  m0_ack,  vecs[i].a0);
      chk($sformatf("row%0d m1_ack", i),  m1_ack,  vecs[i].a1);
      chk($sformatf("row%0d m0_err", i),  m0_err,  vecs[i].r0);
      chk($sformatf("row%0d m1_err", i),  m1_err,  vecs[i].r1);
      chk($sformatf("row%0d m0_dat_r", i), m0_dat_r, 32'hD000_0000 + DATA_W'(i));
      chk($sformatf("row%0d m1_dat_r", i), m1_dat_r, 32'hD000_0000 + DATA_W'(i));
      adv();
    end

    // Burst lock: master 0 served last, so master 1 wins the tie and keeps the bus for 4 beats.
    apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("burst idle s_cyc", s_cyc, 1'b0);
    adv();
    for (int k = 0; k < 4; k++) begin
      m1_cti = (k < 3) ? 3'b010 : 3'b111;
      apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      chk($sformatf("burst%0d m1_ack", k), m1_ack, 1'b1);
      chk($sformatf("burst%0d m0_ack", k), m0_ack, 1'b0);
      chk($sformatf("burst%0d s_adr", k),  s_adr,  30'h200);
      chk($sformatf("burst%0d s_cti", k),  s_cti,  (k < 3) ? 3'b010 : 3'b111);
      adv();
    end
    m1_cti = 3'b000;
    apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("burst drop s_cyc", s_cyc, 1'b0);
    chk("burst drop m0_ack", m0_ack, 1'b0);
    adv();
    @(negedge clk);
    chk("burst turnaround s_cyc", s_cyc, 1'b0);
    adv();
    apply(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("burst m0 grant s_cyc", s_cyc, 1'b1);
    chk("burst m0 grant s_adr", s_adr, 30'h100);
    chk("burst m0 grant m0_ack", m0_ack, 1'b1);
    adv();
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    adv();
    adv();

    // Unresponsive slave: master 0 holds a strobe that is never acknowledged.
    apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    adv();
    errs = 0;
`ifdef WB_ARB_TIMEOUT_EN
    for (int t = 0; t <= 20; t++) begin
      @(negedge clk);
      chk($sformatf("timeout t%0d m0_err", t), m0_err, (t == 16));
      if (t == 16) chk("timeout s_stb held", s_stb, 1'b1);
      adv();
    end
`else
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (m0_err !== 1'b0) errs++;
      adv();
    end
    chk("no timeout err count", 64'(errs), 64'd0);
    @(negedge clk);
    chk("hang s_stb held", s_stb, 1'b1);
`endif
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    adv();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wishbone_rr_arbiter.md
Name: wishbone_rr_arbiter

Overview:
- Two-master to one-slave Wishbone arbiter.
- Lets the instruction-fetch and data Wishbone ports of the core share a single combined instruction/data bus (idbus) toward the SoC interconnect.
- Fair round-robin grant; the grant is held for the whole bus cycle (cyc high), so locked/burst cycles are never split.
- Sits between the core's iwishbone/dwishbone ports and the external idbus pins in the wrapper.

Parameters:
ADDR_W, 30, word address width
DATA_W, 32, data width; SEL_W = DATA_W/8 derived
TIMEOUT_CYCLES, 1024, bus-timeout limit; used only when the optional feature is compiled in

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
m0_adr  in  ADDR_W  master 0 (instruction) address
m0_dat_w  in  DATA_W  master 0 write data
m0_sel  in  SEL_W  master 0 byte select
m0_cyc  in  1  master 0 cycle
m0_stb  in  1  master 0 strobe
m0_we  in  1  master 0 write enable
m0_cti  in  3  master 0 cycle type
m0_bte  in  2  master 0 burst type
m0_dat_r  out  DATA_W  master 0 read data
m0_ack  out  1  master 0 ack
m0_err  out  1  master 0 error
m1_*  (same set as m0_*)  master 1 (data) port, identical widths
s_adr, s_dat_w, s_sel, s_cyc, s_stb, s_we, s_cti, s_bte  out  as above  slave-side request
s_dat_r  in  DATA_W  slave read data
s_ack  in  1  slave ack
s_err  in  1  slave error

Behaviour:
- Clocking and reset: one clock (clk); reset rst_n is synchronous and active-low. All state updates on the rising edge of clk.
- States: IDLE, GNT0, GNT1. Extra register last_gnt (reset 1, so master 0 wins the first tie).
- Reset: state=IDLE, last_gnt=1. All outputs 0 during reset and in IDLE: s_cyc, s_stb, m*_ack, m*_err.
- Reset asserted mid-cycle: back to IDLE on the next edge; s_cyc/s_stb drop that edge. A pending ack is discarded.
- IDLE transitions:
  - only m0_cyc high -> GNT0
  - only m1_cyc high -> GNT1
  - both high -> the master != last_gnt
  - neither -> stay IDLE
- Arbitration latency: exactly 1 cycle. A request seen in IDLE drives s_cyc on the following cycle.
- GNTx:
  - Slave request outputs are a combinational mux of master x's signals.
  - s_dat_r routes to both m*_dat_r.
  - s_ack/s_err gate to master x only; the other master sees ack=0, err=0 and simply stalls.
  - Stay in GNTx while mx_cyc=1.
  - On mx_cyc=0: last_gnt<=x and go to IDLE; s_cyc is 0 in that IDLE cycle (1-cycle bus turnaround).
- Back-to-back: a master that drops and re-raises cyc still passes through IDLE, where the other requester wins if present.
- Ownership ends only on cyc deassertion:
  - a master holding cyc across multiple stb/ack pairs (burst, AMO read-modify-write) keeps the grant;
  - slave err does not end ownership.
- No buffering: data paths are pure muxes; only state and last_gnt are registered.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- When defined:
  - A counter resets to 0 on grant and on each s_ack/s_err, and increments each cycle with s_stb=1 and no ack/err.
  - When it reaches TIMEOUT_CYCLES-1, the arbiter asserts mx_err for one cycle to the granted master (s_stb stays driven) and clears the counter.
  - Counter width is $clog2(TIMEOUT_CYCLES).
- When undefined: no counter; an unresponsive slave hangs the granted master indefinitely.

Decomposition:
- Shared package (l2_config_and_types neighbour or a new wishbone_arb_types package):
  - typedef arb_state_t enum {IDLE, GNT0, GNT1}
  - a packed struct wb_req_t {adr, dat_w, sel, we, cti, bte, cyc, stb}, so the mux is a single assign.
- One natural sub-module: wb_timeout_counter, instantiated only under WB_ARB_TIMEOUT_EN.

Test Plan:
- Reset hold: rst_n=0 for 3 cycles with both cyc high -> s_cyc=0, m0_ack=m1_ack=0 throughout; first grant after release goes to master 0.
- Simultaneous requests: m0 and m1 assert cyc/stb at cycle 5, slave acks after 2 cycles, each master drops cyc after its ack -> order m0, m1, m0, m1; s_adr equals the granted master's address (0x100 vs 0x200); exactly 1 idle cycle between grants.
- Burst lock: m1 holds cyc for 4 ack'd beats (cti=3'b010) while m0 requests -> m0 receives no ack until m1_cyc drops; m0 granted 2 cycles later.
- Error routing: slave asserts s_err on a GNT1 read -> m1_err=1, m0_err=0; grant held until m1_cyc=0.
- Mid-cycle reset: rst_n low during GNT0 with stb pending -> s_cyc=0 on the next edge, state IDLE; m0 re-granted 1 cycle after rst_n high.
- Timeout (WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): slave never acks -> m0_err pulses exactly 1 cycle, 16 cycles after s_stb rose; without the macro, no err after 100 cycles.
